sdu_seq_ctrl: RTL and testbench

SDU_SEQ_CTRL -- requirements
Module: sdu_seq_ctrl

---
 rtl/sdu_seq_pkg.sv | 22 ++
 rtl/sdu_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_sdu_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdu_seq_pkg.sv
// -----------------------------------------------------------------------------
// sdu_seq_pkg
// Shared definitions for the SDU sequence controller: FSM state encoding,
// the minimum inter-sequence gap and the playback watchdog limit.
// No ports; imported by sdu_seq_ctrl.
// -----------------------------------------------------------------------------
package sdu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRE     = 3'd1,
        ST_RECORD   = 3'd2,
        ST_GAP      = 3'd3,
        ST_PLAYBACK = 3'd4
    } sdu_state_e;

    // Recorder needs two cycles after a done strobe before it can re-arm.
    localparam int unsigned SDU_MIN_GAP          = 2;
    // Playback watchdog length in cycles (used only with SDU_SEQ_TIMEOUT_EN).
    localparam int unsigned SDU_PLAYBACK_TIMEOUT = 4096;

endpackage

// File: rtl/sdu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sdu_seq_ctrl
// Sequences a recorder through M transmit/record passes of N samples each,
// separated by idle gaps, then waits for the recorder's playback burst.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run_start, run_abort  one-cycle control strobes (abort has priority)
//   cfg_rec_len/num_avg/gap_len  run configuration, latched on accepted start
//   sdu_rx_strobe         playback-valid from the recorder
//   sdu_tx_fire, sdu_rx_en           one-cycle fire / record-enable pulses
//   sdu_seq_done_strobe, sdu_ave_done_strobe  end of non-final / final pass
//   busy, run_done, avg_count        status
//   err_cfg, err_timeout  sticky error flags
//
// Optional feature: define SDU_SEQ_TIMEOUT_EN to enable the playback
// watchdog; otherwise PLAYBACK waits indefinitely and err_timeout is 0.
// -----------------------------------------------------------------------------
module sdu_seq_ctrl
    import sdu_seq_pkg::*;
#(
    parameter int REC_W = 16,
    parameter int AVG_W = 16,
    parameter int GAP_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_start,
    input  logic             run_abort,
    input  logic [REC_W-1:0] cfg_rec_len,
    input  logic [AVG_W-1:0] cfg_num_avg,
    input  logic [GAP_W-1:0] cfg_gap_len,
    input  logic             sdu_rx_strobe,
    output logic             sdu_tx_fire,
    output logic             sdu_rx_en,
    output logic             sdu_seq_done_strobe,
    output logic             sdu_ave_done_strobe,
    output logic             busy,
    output logic             run_done,
    output logic [AVG_W-1:0] avg_count,
    output logic             err_cfg,
    output logic             err_timeout
);

    sdu_state_e       state_q,   state_d;
    logic [REC_W-1:0] rec_len_q, rec_len_d;
    logic [AVG_W-1:0] num_avg_q, num_avg_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
    logic [AVG_W-1:0] avg_cnt_q, avg_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             seen_q,    seen_d;
    logic             err_cfg_q, err_cfg_d;

    logic             rec_last;
    logic             avg_last;
    logic [GAP_W-1:0] gap_end;

`ifdef SDU_SEQ_TIMEOUT_EN
    localparam int PB_W = $clog2(SDU_PLAYBACK_TIMEOUT);
    logic [PB_W-1:0] pb_cnt_q, pb_cnt_d;
    logic            err_to_q, err_to_d;
`endif

    // Equality-only terminal counts; lengths are >= 1 once latched.
    assign rec_last = (rec_cnt_q == rec_len_q - REC_W'(1));
    assign avg_last = (avg_cnt_q == num_avg_q - AVG_W'(1));
    // GAP lasts max(gap,2)-1 cycles, so FIRE lands max(gap,2) after the done strobe.
    assign gap_end  = (gap_len_q < GAP_W'(SDU_MIN_GAP)) ? '0
                                                         : gap_len_q - GAP_W'(SDU_MIN_GAP);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d   = state_q;
        rec_len_d = rec_len_q;
        num_avg_d = num_avg_q;
        gap_len_d = gap_len_q;
        rec_cnt_d = rec_cnt_q;
        avg_cnt_d = avg_cnt_q;
        gap_cnt_d = gap_cnt_q;
        seen_d    = seen_q;
        err_cfg_d = err_cfg_q;
`ifdef SDU_SEQ_TIMEOUT_EN
        pb_cnt_d  = pb_cnt_q;
        err_to_d  = err_to_q;
`endif
        sdu_tx_fire         = 1'b0;
        sdu_rx_en           = 1'b0;
        sdu_seq_done_strobe = 1'b0;
        sdu_ave_done_strobe = 1'b0;
        run_done            = 1'b0;

        if (run_abort) begin
            // Abort wins over everything; only RECORD needs a strobe so the
            // recorder leaves its recording state. Counters are left as-is.
            state_d             = ST_IDLE;
            sdu_seq_done_strobe = (state_q == ST_RECORD);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_start) begin
                        if (cfg_rec_len != '0 && cfg_num_avg != '0) begin
                            rec_len_d = cfg_rec_len;
                            num_avg_d = cfg_num_avg;
                            gap_len_d = cfg_gap_len;
                            avg_cnt_d = '0;
`ifdef SDU_SEQ_TIMEOUT_EN
                            err_to_d  = 1'b0;
`endif
                            state_d   = ST_FIRE;
                        end else begin
                            err_cfg_d = 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    sdu_tx_fire = 1'b1;
                    sdu_rx_en   = 1'b1;
                    rec_cnt_d   = '0;
                    state_d     = ST_RECORD;
                end
                ST_RECORD: begin
                    if (rec_last) begin
                        avg_cnt_d = avg_cnt_q + AVG_W'(1);
                        gap_cnt_d = '0;
                        seen_d    = 1'b0;
`ifdef SDU_SEQ_TIMEOUT_EN
                        pb_cnt_d  = '0;
`endif
                        if (avg_last) begin
                            sdu_ave_done_strobe = 1'b1;
                            state_d             = ST_PLAYBACK;
                        end else begin
                            sdu_seq_done_strobe = 1'b1;
                            state_d             = ST_GAP;
                        end
                    end else begin
                        rec_cnt_d = rec_cnt_q + REC_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == gap_end) begin
                        state_d = ST_FIRE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_PLAYBACK: begin
                    // Completion is the first low cycle after playback was seen high.
                    if (seen_q && !sdu_rx_strobe) begin
                        run_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        if (sdu_rx_strobe) begin
                            seen_d = 1'b1;
                        end
`ifdef SDU_SEQ_TIMEOUT_EN
                        if (pb_cnt_q == PB_W'(SDU_PLAYBACK_TIMEOUT - 1)) begin
                            err_to_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            pb_cnt_d = pb_cnt_q + PB_W'(1);
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A run cut by reset must not leave a stray strobe behind.
        if (reset) begin
            sdu_tx_fire         = 1'b0;
            sdu_rx_en           = 1'b0;
            sdu_seq_done_strobe = 1'b0;
            sdu_ave_done_strobe = 1'b0;
            run_done            = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: latched config is reset too, so a post-reset run never sees stale lengths.
            state_q   <= ST_IDLE;
            rec_len_q <= '0;
            num_avg_q <= '0;
            gap_len_q <= '0;
            rec_cnt_q <= '0;
            avg_cnt_q <= '0;
            gap_cnt_q <= '0;
            seen_q    <= 1'b0;
            err_cfg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_len_q <= rec_len_d;
            num_avg_q <= num_avg_d;
            gap_len_q <= gap_len_d;
            rec_cnt_q <= rec_cnt_d;
            avg_cnt_q <= avg_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            seen_q    <= seen_d;
            err_cfg_q <= err_cfg_d;
        end
    end

`ifdef SDU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_cnt_q <= '0;
            err_to_q <= 1'b0;
        end else begin
            pb_cnt_q <= pb_cnt_d;
            err_to_q <= err_to_d;
        end
    end
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign avg_count = avg_cnt_q;
    assign err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_sdu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdu_seq_ctrl
// Scoreboard bench for sdu_seq_ctrl. The driver derives the cycle of every
// fire / done / run_done event from the run parameters and queues it; a
// monitor on the falling edge pops and compares whenever the DUT pulses.
// Build with SDU_SEQ_TIMEOUT_EN defined to exercise the playback watchdog.
// -----------------------------------------------------------------------------
module tb_sdu_seq_ctrl;

    localparam int REC_W = 16;
    localparam int AVG_W = 16;
    localparam int GAP_W = 24;

    localparam int EV_NONE = 0;
    localparam int EV_FIRE = 1;
    localparam int EV_SEQ  = 2;
    localparam int EV_AVE  = 3;
    localparam int EV_DONE = 4;

    logic             clk;
    logic             reset;
    logic             run_start;
    logic             run_abort;
    logic [REC_W-1:0] cfg_rec_len;
    logic [AVG_W-1:0] cfg_num_avg;
    logic [GAP_W-1:0] cfg_gap_len;
    logic             sdu_rx_strobe;
    logic             sdu_tx_fire;
    logic             sdu_rx_en;
    logic             sdu_seq_done_strobe;
    logic             sdu_ave_done_strobe;
    logic             busy;
    logic             run_done;
    logic [AVG_W-1:0] avg_count;
    logic             err_cfg;
    logic             err_timeout;

    sdu_seq_ctrl #(
        .REC_W(REC_W),
        .AVG_W(AVG_W),
        .GAP_W(GAP_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .run_start           (run_start),
        .run_abort           (run_abort),
        .cfg_rec_len         (cfg_rec_len),
        .cfg_num_avg         (cfg_num_avg),
        .cfg_gap_len         (cfg_gap_len),
        .sdu_rx_strobe       (sdu_rx_strobe),
        .sdu_tx_fire         (sdu_tx_fire),
        .sdu_rx_en           (sdu_rx_en),
        .sdu_seq_done_strobe (sdu_seq_done_strobe),
        .sdu_ave_done_strobe (sdu_ave_done_strobe),
        .busy                (busy),
        .run_done            (run_done),
        .avg_count           (avg_count),
        .err_cfg             (err_cfg),
        .err_timeout         (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number: value of cyc during a cycle is the count of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int avg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic push_exp(input int kind, input int c, input int avg);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.avg  = avg;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic scramble_cfg();
        cfg_rec_len = REC_W'($urandom_range(0, 9));
        cfg_num_avg = AVG_W'($urandom_range(0, 5));
        cfg_gap_len = GAP_W'($urandom_range(0, 9));
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin : mon
            int   ev;
            exp_t e;
            @(negedge clk);
            ev = EV_NONE;
            if (sdu_tx_fire === 1'b1)         ev = EV_FIRE;
            if (sdu_seq_done_strobe === 1'b1) ev = EV_SEQ;
            if (sdu_ave_done_strobe === 1'b1) ev = EV_AVE;
            if (run_done === 1'b1)            ev = EV_DONE;
            if (sdu_seq_done_strobe === 1'b1 && sdu_ave_done_strobe === 1'b1)
                check("seq_ave_exclusive", 1, 0);
            if (ev != EV_NONE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", ev, EV_NONE);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", ev, e.kind);
                    check("event_cycle", cyc, e.cyc);
                    if (ev == EV_FIRE) check("rx_en_with_fire", sdu_rx_en, 1);
                    else               check("avg_count_at_event", avg_count, e.avg);
                end
            end else if (sdu_rx_en === 1'b1) begin
                check("rx_en_without_fire", 1, 0);
            end
        end
    end

    // ---------------- reference-model driven run ----------------
    // Schedule: FIRE at start+1; done N cycles after each FIRE; next FIRE
    // max(gap,2) cycles after a non-final done; playback burst of len l
    // starts dly cycles after PLAYBACK entry; run_done on its first low cycle.
    task automatic run_seq(input int n, input int m, input int g, input int l,
                           input int dly, input bit noise);
        int t0, f, d, pb_hi, rdone, gap_eff;
        tick();
        t0          = cyc;
        cfg_rec_len = REC_W'(n);
        cfg_num_avg = AVG_W'(m);
        cfg_gap_len = GAP_W'(g);
        run_start   = 1'b1;
        gap_eff     = (g < 2) ? 2 : g;
        f = t0 + 1;
        d = f;
        for (int k = 0; k < m; k++) begin
            push_exp(EV_FIRE, f, 0);
            d = f + n;
            push_exp((k == m - 1) ? EV_AVE : EV_SEQ, d, k);
            f = d + gap_eff;
        end
        pb_hi = d + 1 + dly;
        rdone = pb_hi + l;
        push_exp(EV_DONE, rdone, m);
        tick();
        run_start = 1'b0;
        check("busy_after_start", busy, 1);
        while (cyc < rdone + 1) begin
            tick();
            if (noise) begin
                scramble_cfg();
                run_start = (cyc < rdone) ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            sdu_rx_strobe = (cyc >= pb_hi && cyc < rdone);
        end
        run_start = 1'b0;
        check("busy_after_run", busy, 0);
        check("avg_count_final", avg_count, m);
        check("err_timeout_after_run", err_timeout, 0);
    endtask

    task automatic bad_start(input int n, input int m);
        tick();
        cfg_rec_len = REC_W'(n);
        cfg_num_avg = AVG_W'(m);
        cfg_gap_len = GAP_W'(3);
        run_start   = 1'b1;
        tick();
        run_start = 1'b0;
        check("err_cfg_set", err_cfg, 1);
        check("busy_bad_cfg", busy, 0);
        repeat (4) tick();
        check("busy_bad_cfg_later", busy, 0);
    endtask

    task automatic begin_run(input int n, input int m, input int g, output int t0);
        tick();
        t0          = cyc;
        cfg_rec_len = REC_W'(n);
        cfg_num_avg = AVG_W'(m);
        cfg_gap_len = GAP_W'(g);
        run_start   = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : drv
        int t0;
        reset         = 1'b1;
        run_start     = 1'b0;
        run_abort     = 1'b0;
        cfg_rec_len   = '0;
        cfg_num_avg   = '0;
        cfg_gap_len   = '0;
        sdu_rx_strobe = 1'b0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_avg_count", avg_count, 0);
        check("reset_err_cfg", err_cfg, 0);
        check("reset_err_timeout", err_timeout, 0);
        check("reset_fire", sdu_tx_fire, 0);
        reset = 1'b0;

        // Start at cycle 10: fire 11, ave_done 15, playback 16-20, run_done 21.
        wait_until(9);
        run_seq(4, 1, 0, 5, 0, 1'b0);
        // Three passes with gap 5.
        run_seq(3, 3, 5, 2, 1, 1'b0);
        // Gap below the minimum.
        run_seq(2, 2, 1, 1, 0, 1'b0);
        run_seq(5, 3, 0, 3, 2, 1'b0);
        // Single-sample record.
        run_seq(1, 2, 0, 1, 2, 1'b0);

        // Randomized runs with config churn and ignored starts while busy.
        for (int i = 0; i < 20; i++) begin
            run_seq($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 7),
                    $urandom_range(1, 4), $urandom_range(0, 3), 1'b1);
        end
        check("err_cfg_clean_after_runs", err_cfg, 0);

        // Invalid config: zero record length.
        bad_start(0, 2);

        // Abort on the last RECORD cycle of the final pass: seq_done, not ave_done.
        begin_run(3, 1, 0, t0);
        push_exp(EV_FIRE, t0 + 1, 0);
        push_exp(EV_SEQ, t0 + 4, 0);
        wait_until(t0 + 4);
        run_abort = 1'b1;
        tick();
        run_abort = 1'b0;
        check("busy_after_abort_record", busy, 0);
        repeat (8) tick();

        // Abort in GAP: no strobe, no further FIRE.
        begin_run(2, 2, 6, t0);
        push_exp(EV_FIRE, t0 + 1, 0);
        push_exp(EV_SEQ, t0 + 3, 0);
        wait_until(t0 + 5);
        run_abort = 1'b1;
        tick();
        run_abort = 1'b0;
        check("busy_after_abort_gap", busy, 0);
        repeat (8) tick();

        // Abort on the cycle that would otherwise complete the run.
        begin_run(2, 1, 0, t0);
        push_exp(EV_FIRE, t0 + 1, 0);
        push_exp(EV_AVE, t0 + 3, 0);
        wait_until(t0 + 4);
        sdu_rx_strobe = 1'b1;
        tick();
        sdu_rx_strobe = 1'b0;
        run_abort     = 1'b1;
        tick();
        run_abort = 1'b0;
        check("busy_after_abort_playback", busy, 0);
        repeat (6) tick();

        // Reset on the final RECORD cycle: no strobe, everything cleared.
        begin_run(4, 1, 0, t0);
        push_exp(EV_FIRE, t0 + 1, 0);
        wait_until(t0 + 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("busy_after_reset", busy, 0);
        check("avg_count_after_reset", avg_count, 0);
        check("err_cfg_after_reset", err_cfg, 0);
        check("run_done_after_reset", run_done, 0);
        repeat (6) tick();

        // Invalid config: zero average count.
        bad_start(3, 0);

        // Playback with no recorder response.
        begin_run(1, 1, 0, t0);
        push_exp(EV_FIRE, t0 + 1, 0);
        push_exp(EV_AVE, t0 + 2, 0);
`ifdef SDU_SEQ_TIMEOUT_EN
        wait_until(t0 + 3 + 4095);
        check("timeout_not_yet", err_timeout, 0);
        check("busy_before_timeout", busy, 1);
        tick();
        check("timeout_fired", err_timeout, 1);
        check("busy_after_timeout", busy, 0);
        repeat (4) tick();
        run_seq(2, 1, 0, 2, 0, 1'b0);
`else
        wait_until(t0 + 3 + 4200);
        check("busy_no_timeout", busy, 1);
        check("err_timeout_tied", err_timeout, 0);
        run_abort = 1'b1;
        tick();
        run_abort = 1'b0;
        check("busy_after_abort_wait", busy, 0);
`endif

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
